scpad_beat_assembler: RTL
=========================

SCPAD_BEAT_ASSEMBLER -- requirements
Module: scpad_beat_assembler

Interface
REQ-001 SHALL have parameter ELEM_BITS, default 16, element width in bits.
REQ-002 SHALL have parameter NUM_COLS, default 32, elements per scratchpad row.
REQ-003 SHALL have parameter BUS_BITS, default 64, DRAM beat width; LANES=BUS_BITS/ELEM_BITS (4), BEATS=NUM_COLS/LANES (8), BEAT_W=clog2(BEATS).
REQ-004 SHALL have parameter NUM_SLOTS, default 4, outstanding row buffers; SLOT_W=clog2(NUM_SLOTS).
REQ-005 SHALL have parameter ADDR_W, default 20, scratchpad byte-address width.
REQ-006 Ports: clk  in  1  clock; all state updates on rising edge.
REQ-007 n_rst  in  1  reset, asynchronous, active-low.
REQ-008 alloc_valid  in  1  request to open a row buffer.
REQ-009 alloc_ready  out  1  a FREE slot exists.
REQ-010 alloc_spad_addr  in  ADDR_W  destination row address.
REQ-011 alloc_num_beats  in  BEAT_W+1  expected beats, legal range 1..BEATS.
REQ-012 alloc_slot  out  SLOT_W  slot granted, valid while alloc_ready.
REQ-013 res_valid  in  1  DRAM response beat present.
REQ-014 res_id  in  SLOT_W+BEAT_W  {slot, beat index}.
REQ-015 res_mask  in  LANES  per-lane valid.
REQ-016 res_rdata  in  BUS_BITS  beat data, lane 0 in LSBs.
REQ-017 wr_valid  out  1  assembled row ready for SRAM write.
REQ-018 wr_ready  in  1  SRAM write accepted.
REQ-019 wr_spad_addr  out  ADDR_W  row address of emitted row.
REQ-020 wr_wdata  out  NUM_COLS*ELEM_BITS  assembled row, element 0 in LSBs.
REQ-021 wr_valid_mask  out  NUM_COLS  elements written by any beat.
REQ-022 err_stray  out  1  one-cycle pulse on illegal response.
REQ-023 busy  out  1  any slot not FREE.

Function
REQ-024 Each slot SHALL hold state FREE, FILLING or READY plus addr, num_beats, beat count, beat-seen bitmap, data and element mask.
REQ-025 alloc_ready SHALL be 1 iff a slot is FREE in registered state; alloc_slot SHALL be the lowest-index FREE slot.
REQ-026 Alloc fire (alloc_valid&alloc_ready) SHALL move that slot FREE->FILLING, load addr/num_beats, clear count, bitmap, data, mask, and push slot index to an in-order queue of depth NUM_SLOTS.
REQ-027 A legal beat (slot FILLING, beat<num_beats, beat bit unseen) SHALL write lane i of res_rdata into element beat*LANES+i where res_mask[i]=1, set those mask bits, set the bitmap bit, and increment count.
REQ-028 When a legal beat makes count equal num_beats, the slot SHALL be READY on the next edge.
REQ-029 Illegal beats (slot not FILLING, beat>=num_beats, or duplicate beat) SHALL alter no state and SHALL pulse err_stray the following cycle.
REQ-030 Beats MAY arrive in any order and interleaved across slots.
REQ-031 wr_valid SHALL be 1 iff the slot at queue head is READY; wr_* SHALL reflect that slot combinationally from registers.
REQ-032 Rows SHALL be emitted strictly in allocation order even if a younger slot completes first.
REQ-033 wr_valid&wr_ready SHALL pop the queue and return the slot to FREE on that edge; wr_* SHALL hold stable while wr_valid&!wr_ready.
REQ-034 A slot freed in cycle N SHALL be allocatable no earlier than cycle N+1.
REQ-035 Alloc, legal beat and write pop in the same cycle on distinct slots SHALL all take effect.
REQ-036 Latency: final beat accepted at edge N -> wr_valid high in cycle N+1 when slot is head.

Reset
REQ-037 While n_rst=0 all slots SHALL be FREE, queue empty, data/mask zero; alloc_ready=1, alloc_slot=0, wr_valid=0, wr_spad_addr=0, wr_wdata=0, wr_valid_mask=0, err_stray=0, busy=0.
REQ-038 Reset asserted mid-fill SHALL discard all partial rows with no write emitted afterwards.

Verification
REQ-039 Alloc addr 0x100, 8 beats; send beats 7..0 all-mask, data=beat index -> one write, addr 0x100, element k = k/4, mask all-ones, wr_valid one cycle after last beat.
REQ-040 Alloc slots 0,1; complete slot 1 first -> wr_valid stays 0 until slot 0 done; slot 0 emitted before slot 1.
REQ-041 Fill all 4 slots -> alloc_ready=0; one write pop -> alloc_ready=1 next cycle, alloc_slot = freed slot.
REQ-042 Beat 2 sent twice; beat to FREE slot; beat 5 with num_beats=4 -> err_stray pulses three times, row data unchanged.
REQ-043 num_beats=2, res_mask=4'b0101 both beats -> wr_valid_mask=0x00000055, unmasked elements zero.
REQ-044 Assert n_rst low after 3 of 8 beats -> all outputs at reset values, no write after release.

Source files
------------

// File: rtl/scpad_beat_assembler.sv
// Collects out-of-order DRAM response beats into full scratchpad rows.
// Rows are handed to the SRAM write port strictly in allocation order.
module scpad_beat_assembler #(
    parameter  int ELEM_BITS = 16,
    parameter  int NUM_COLS  = 32,
    parameter  int BUS_BITS  = 64,
    parameter  int NUM_SLOTS = 4,
    parameter  int ADDR_W    = 20,
    localparam int LANES     = BUS_BITS / ELEM_BITS,
    localparam int BEATS     = NUM_COLS / LANES,
    localparam int BEAT_W    = $clog2(BEATS),
    localparam int SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          alloc_valid,
    output logic                          alloc_ready,
    input  logic [ADDR_W-1:0]             alloc_spad_addr,
    input  logic [BEAT_W:0]               alloc_num_beats,
    output logic [SLOT_W-1:0]             alloc_slot,
    input  logic                          res_valid,
    input  logic [SLOT_W+BEAT_W-1:0]      res_id,
    input  logic [LANES-1:0]              res_mask,
    input  logic [BUS_BITS-1:0]           res_rdata,
    output logic                          wr_valid,
    input  logic                          wr_ready,
    output logic [ADDR_W-1:0]             wr_spad_addr,
    output logic [NUM_COLS*ELEM_BITS-1:0] wr_wdata,
    output logic [NUM_COLS-1:0]           wr_valid_mask,
    output logic                          err_stray,
    output logic                          busy
);
    localparam int LANE_W = $clog2(LANES);
    localparam int COL_W  = $clog2(NUM_COLS);

    typedef enum logic [1:0] {S_FREE, S_FILL, S_READY} state_e;

    state_e                              st_q   [NUM_SLOTS];
    logic [ADDR_W-1:0]                   addr_q [NUM_SLOTS];
    logic [BEAT_W:0]                     nb_q   [NUM_SLOTS];
    logic [BEAT_W:0]                     cnt_q  [NUM_SLOTS];
    logic [BEATS-1:0]                    seen_q [NUM_SLOTS];
    logic [NUM_COLS-1:0][ELEM_BITS-1:0]  data_q [NUM_SLOTS];
    logic [NUM_COLS-1:0]                 mask_q [NUM_SLOTS];
    logic [SLOT_W-1:0]                   fifo_q [NUM_SLOTS];

    logic [SLOT_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [SLOT_W:0]   qcnt_q, qcnt_d;
    logic              err_q, err_d;

    logic [SLOT_W-1:0] res_slot, head_slot;
    logic [BEAT_W-1:0] res_beat;
    logic              legal, alloc_fire, pop, found;

    assign res_slot  = res_id[SLOT_W+BEAT_W-1:BEAT_W];
    assign res_beat  = res_id[BEAT_W-1:0];
    assign head_slot = fifo_q[head_q];

    // Lowest-index free slot wins the grant.
    always_comb begin
        found      = 1'b0;
        alloc_slot = '0;
        busy       = 1'b0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (st_q[s] != S_FREE) busy = 1'b1;
            if (st_q[s] == S_FREE && !found) begin
                found      = 1'b1;
                alloc_slot = SLOT_W'(s);
            end
        end
    end

    assign alloc_ready   = found;
    assign alloc_fire    = alloc_valid && alloc_ready;
    assign legal         = res_valid && (st_q[res_slot] == S_FILL) &&
                           ({1'b0, res_beat} < nb_q[res_slot]) &&
                           !seen_q[res_slot][res_beat];
    assign wr_valid      = (qcnt_q != '0) && (st_q[head_slot] == S_READY);
    assign pop           = wr_valid && wr_ready;
    assign wr_spad_addr  = addr_q[head_slot];
    assign wr_wdata      = data_q[head_slot];
    assign wr_valid_mask = mask_q[head_slot];
    assign err_stray     = err_q;

    always_comb begin
        err_d  = res_valid && !legal;
        head_d = head_q;
        tail_d = tail_q;
        qcnt_d = qcnt_q;
        if (alloc_fire)
            tail_d = (tail_q == SLOT_W'(NUM_SLOTS - 1)) ? '0 : tail_q + 1'b1;
        if (pop)
            head_d = (head_q == SLOT_W'(NUM_SLOTS - 1)) ? '0 : head_q + 1'b1;
        if (alloc_fire && !pop)      qcnt_d = qcnt_q + 1'b1;
        else if (!alloc_fire && pop) qcnt_d = qcnt_q - 1'b1;
    end

    // Alloc, beat and pop always target slots in different states, so they never collide.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                st_q[s]   <= S_FREE;
                addr_q[s] <= '0;
                nb_q[s]   <= '0;
                cnt_q[s]  <= '0;
                seen_q[s] <= '0;
                data_q[s] <= '0;
                mask_q[s] <= '0;
                fifo_q[s] <= '0;
            end
            head_q <= '0;
            tail_q <= '0;
            qcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            qcnt_q <= qcnt_d;
            err_q  <= err_d;
            if (alloc_fire) begin
                st_q[alloc_slot]   <= S_FILL;
                addr_q[alloc_slot] <= alloc_spad_addr;
                nb_q[alloc_slot]   <= alloc_num_beats;
                cnt_q[alloc_slot]  <= '0;
                seen_q[alloc_slot] <= '0;
                data_q[alloc_slot] <= '0;
                mask_q[alloc_slot] <= '0;
                fifo_q[tail_q]     <= alloc_slot;
            end
            if (legal) begin
                for (int i = 0; i < LANES; i++) begin
                    if (res_mask[i]) begin
                        data_q[res_slot][COL_W'({res_beat, LANE_W'(i)})] <=
                            res_rdata[i*ELEM_BITS +: ELEM_BITS];
                        mask_q[res_slot][COL_W'({res_beat, LANE_W'(i)})] <= 1'b1;
                    end
                end
                seen_q[res_slot][res_beat] <= 1'b1;
                cnt_q[res_slot]            <= cnt_q[res_slot] + 1'b1;
                if (cnt_q[res_slot] + 1'b1 == nb_q[res_slot])
                    st_q[res_slot] <= S_READY;
            end
            if (pop) st_q[head_slot] <= S_FREE;
        end
    end
endmodule
